rs_encoder225: RTL
==================

RS_ENCODER225 -- requirements
Module: rs_encoder225

Interface
REQ-001 Parameter: number_of_coefs, default 30, count of parity symbols per codeword.
REQ-002 Parameter: msg_len, default 225, count of message bytes per codeword.
REQ-003 Parameter: width, default 6, bit width of the parity index output.
REQ-004 clock  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 data_in  input  8  message byte, highest-degree coefficient first.
REQ-007 data_in_valid  input  1  data_in holds a valid message byte.
REQ-008 data_in_ready  output  1  block accepts data_in this cycle.
REQ-009 enc_out  output  8  codeword byte: message bytes first, then parity bytes.
REQ-010 enc_out_valid  output  1  enc_out holds a valid byte.
REQ-011 enc_out_ready  input  1  downstream consumes enc_out this cycle.
REQ-012 codeword_start  output  1  high with the first byte of each codeword.
REQ-013 codeword_end  output  1  high with the last parity byte of each codeword.
REQ-014 parity_idx  output  width  index of the current parity byte, 0..number_of_coefs-1; 0 during the message phase.

Function
REQ-015 The block SHALL form RS(255,225) over GF(2^8) with primitive polynomial 0x11D and generator roots alpha^1..alpha^30.
- These are the same roots the syndromes225 decoder checks.
REQ-016 A transfer SHALL occur on an input or output port when valid and ready are both high in the same cycle.
REQ-017 The FSM SHALL have two states.
- MSG: reset state.
- PARITY: entered after the msg_len-th input transfer.
REQ-018 data_in_ready SHALL be (state==MSG) && (!enc_out_valid || enc_out_ready).
REQ-019 Each accepted message byte SHALL appear on enc_out exactly one cycle after its input transfer, unmodified.
REQ-020 On each accepted byte, the LFSR SHALL update as follows.
- feedback = data_in ^ r[29].
- r[j] = r[j-1] ^ g[j]*feedback, with r[-1] = 0.
- All multiplies are GF constant multiplies.
REQ-021 In PARITY, each enc_out transfer SHALL advance the parity output:
- present the next parity byte r[29] down to r[0];
- shift the register without feedback.
REQ-022 After the 30th parity transfer, the block SHALL clear the LFSR and the byte counter and return to MSG in the next cycle.
REQ-023 With continuous valid/ready the block SHALL sustain throughput of 1 byte/cycle: 255 cycles per codeword.
REQ-024 When an output transfer and a new input transfer occur in the same cycle, the block SHALL accept both with no bubble.
REQ-025 With enc_out_ready low, enc_out, enc_out_valid, codeword_start, codeword_end and parity_idx SHALL hold stable.
REQ-026 The byte counter SHALL be 8 bits and never exceed 254.
REQ-027 parity_idx SHALL not wrap past number_of_coefs-1.

Reset
REQ-028 While reset is low, the block SHALL be in state MSG.
REQ-029 While reset is low, the LFSR, byte counter and parity_idx SHALL be 0.
REQ-030 While reset is low, the following outputs SHALL be 0:
- enc_out_valid, enc_out, codeword_start, codeword_end;
- data_in_ready.
REQ-031 A reset mid-codeword SHALL discard the partial codeword; the next accepted byte is message byte 0.

Configuration
REQ-032 Macro RS_ENC_ERR_INJECT_EN defined SHALL add three input ports:
- err_inject (1 bit);
- err_pos (8 bits);
- err_val (8 bits).
REQ-033 With RS_ENC_ERR_INJECT_EN, when err_inject is high, the output byte at codeword position err_pos SHALL be XORed with err_val.
- Position 0 is the first message byte.
- Injection is applied at output only; LFSR/parity calculation is unaffected.
REQ-034 Without RS_ENC_ERR_INJECT_EN, these ports SHALL be absent and enc_out SHALL be the clean codeword.

Structure
REQ-035 A shared package SHALL hold the following:
- GF(2^8) multiply function (0x11D);
- generator coefficients g[0..29], precomputed;
- constants number_of_coefs, msg_len and codeword length 255;
- FSM state encoding.
REQ-036 One sub-module, rs_enc_lfsr, SHALL contain the 30x8 parity register, constant multipliers, load/shift/clear control.

Verification
REQ-037 225 bytes of 0x00, always ready -> 255 output bytes all 0x00; codeword_end on output byte 254.
REQ-038 224 bytes 0x00 then one byte 0x01 -> 30 parity bytes equal g[29]..g[0] in order.
REQ-039 Random message, output fed to syndromes225 -> all 30 syndromes 0x00.
REQ-040 With RS_ENC_ERR_INJECT_EN, err_pos=10, err_val=0x5A -> syndromes225 reports nonzero syndromes consistent with one error at position 10.
REQ-041 enc_out_ready toggled pseudo-randomly at 50% -> output identical to the no-stall run.
- enc_out remains stable during every stall.
REQ-042 Reset pulsed low after 100 accepted bytes, then a full message sent -> output equals the clean encoding of the new message only.

Source files
------------

// File: rtl/rs_encoder225_pkg.sv
// Shared GF(2^8) arithmetic, RS(255,225) generator coefficients and FSM encoding.
// Used by rs_encoder225 (optional error injection via RS_ENC_ERR_INJECT_EN).
package rs_encoder225_pkg;

  localparam int unsigned NUM_COEFS = 30;
  localparam int unsigned MSG_LEN   = 225;
  localparam int unsigned CW_LEN    = 255;

  typedef enum logic {
    StMsg    = 1'b0,
    StParity = 1'b1
  } state_e;

  typedef logic [NUM_COEFS-1:0][7:0] gen_t;

  // GF(2^8) multiply, primitive polynomial 0x11D
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1d : 8'h00);
    end
    return p;
  endfunction

  // Low-order coefficients of prod_{i=1..30} (x + alpha^i); the monic x^30 term is implicit
  function automatic gen_t gen_poly();
    logic [7:0] g [0:NUM_COEFS];
    logic [7:0] root;
    gen_t       res;
    for (int j = 0; j <= NUM_COEFS; j++) g[j] = 8'h00;
    g[0] = 8'h01;
    root = 8'h01;
    for (int i = 1; i <= NUM_COEFS; i++) begin
      root = gf_mul(root, 8'h02);
      for (int j = i; j > 0; j--) g[j] = g[j-1] ^ gf_mul(g[j], root);
      g[0] = gf_mul(g[0], root);
    end
    for (int j = 0; j < NUM_COEFS; j++) res[j] = g[j];
    return res;
  endfunction

  localparam gen_t GEN = gen_poly();

endpackage

// File: rtl/rs_enc_lfsr.sv
// 30-stage systematic RS parity register: feedback load, plain shift-out and clear.
// Part of rs_encoder225 (RS_ENC_ERR_INJECT_EN does not affect this block).
module rs_enc_lfsr
  import rs_encoder225_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic       shift,
  input  logic       clear,
  input  logic [7:0] data_in,
  output logic [7:0] parity_out
);

  logic [NUM_COEFS-1:0][7:0] r_q;
  logic [NUM_COEFS-1:0][7:0] r_d;
  logic [7:0]                fb;

  assign fb         = data_in ^ r_q[NUM_COEFS-1];
  assign parity_out = r_q[NUM_COEFS-1];

  always_comb begin
    r_d = r_q;
    if (clear) begin
      r_d = '0;
    end else if (load) begin
      r_d[0] = gf_mul(GEN[0], fb);
      for (int j = 1; j < NUM_COEFS; j++) r_d[j] = r_q[j-1] ^ gf_mul(GEN[j], fb);
    end else if (shift) begin
      r_d = {r_q[NUM_COEFS-2:0], 8'h00};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_q <= '0;
    else        r_q <= r_d;
  end

endmodule

// File: rtl/rs_encoder225.sv
// Streaming systematic RS(255,225) encoder with a one-deep registered output stage.
// Define RS_ENC_ERR_INJECT_EN to add err_inject/err_pos/err_val output corruption ports.
module rs_encoder225
  import rs_encoder225_pkg::*;
#(
  parameter int unsigned number_of_coefs = 30,
  parameter int unsigned msg_len         = 225,
  parameter int unsigned width           = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       data_in,
  input  logic             data_in_valid,
  output logic             data_in_ready,
  output logic [7:0]       enc_out,
  output logic             enc_out_valid,
  input  logic             enc_out_ready,
  output logic             codeword_start,
  output logic             codeword_end,
  output logic [width-1:0] parity_idx
`ifdef RS_ENC_ERR_INJECT_EN
  ,
  input  logic             err_inject,
  input  logic [7:0]       err_pos,
  input  logic [7:0]       err_val
`endif
);

  localparam logic [7:0] MsgLast = 8'(msg_len - 1);
  localparam logic [7:0] CwLast  = 8'(msg_len + number_of_coefs - 1);
  localparam logic [7:0] MsgLen8 = 8'(msg_len);

  state_e     state_q;
  logic [7:0] cnt_q;
  logic       out_free;
  logic       in_fire;
  logic       par_load;
  logic       par_last;
  logic [7:0] par_byte;
  logic [7:0] inj;

  assign out_free      = !enc_out_valid || enc_out_ready;
  assign data_in_ready = reset && (state_q == StMsg) && out_free;
  assign in_fire       = data_in_ready && data_in_valid;
  assign par_load      = (state_q == StParity) && out_free;
  // Loading the last parity byte already frees the block for the next message byte
  assign par_last      = par_load && (cnt_q == CwLast);

`ifdef RS_ENC_ERR_INJECT_EN
  assign inj = (err_inject && (err_pos == cnt_q)) ? err_val : 8'h00;
`else
  assign inj = 8'h00;
`endif

  rs_enc_lfsr u_lfsr (
    .clock      (clock),
    .reset      (reset),
    .load       (in_fire),
    .shift      (par_load && !par_last),
    .clear      (par_last),
    .data_in    (data_in),
    .parity_out (par_byte)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= StMsg;
      cnt_q          <= 8'h00;
      enc_out        <= 8'h00;
      enc_out_valid  <= 1'b0;
      codeword_start <= 1'b0;
      codeword_end   <= 1'b0;
      parity_idx     <= '0;
    end else if (in_fire) begin
      enc_out        <= data_in ^ inj;
      enc_out_valid  <= 1'b1;
      codeword_start <= (cnt_q == 8'h00);
      codeword_end   <= 1'b0;
      parity_idx     <= '0;
      cnt_q          <= cnt_q + 8'h01;
      if (cnt_q == MsgLast) state_q <= StParity;
    end else if (par_load) begin
      enc_out        <= par_byte ^ inj;
      enc_out_valid  <= 1'b1;
      codeword_start <= 1'b0;
      codeword_end   <= par_last;
      parity_idx     <= width'(cnt_q - MsgLen8);
      if (par_last) begin
        cnt_q   <= 8'h00;
        state_q <= StMsg;
      end else begin
        cnt_q <= cnt_q + 8'h01;
      end
    end else if (enc_out_ready) begin
      enc_out_valid <= 1'b0;
    end
  end

endmodule
